commit_trace_checker: RTL and testbench
=======================================

Name: commit_trace_checker

Overview:
- Hardware counterpart of the commit-trace dump: consumes the live fetch stream (pc, inst) of top_parts and reconstructs the same commit sequence.
- Commit sequence rule: pc-change detection feeding a 5-deep history; the evicted entry is a commit when its pc is nonzero.
- Reads the expected (pc, inst) per commit from a golden trace ROM, compares in order, and reports pass/fail with the first mismatch captured.
- Sits beside the CPU top for FPGA self-check, with no simulator file I/O.

Parameters:
TRACE_LEN, 1000, number of commits that must match before PASS
ADDR_W, 10, golden ROM index width; must satisfy 2^ADDR_W >= TRACE_LEN
HIST_DEPTH, 5, pc/inst history depth; the evicted entry is the commit candidate (minimum 1)
TIMEOUT, 4096, cycles without a pc change in RUN before FAIL

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-high; sampled on posedge clk
pc  in  32  current fetch pc from CPU
inst  in  32  current fetch instruction from CPU
gold_addr  out  ADDR_W  golden ROM read index
gold_pc  in  32  ROM pc data; synchronous read, valid 1 cycle after gold_addr
gold_inst  in  32  ROM inst data, same timing as gold_pc
checked_count  out  ADDR_W+1  commits compared and matched
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
fail_code  out  3  bit0 pc mismatch, bit1 inst mismatch, bit2 timeout
mismatch_idx  out  ADDR_W+1  index of first failing commit
mismatch_pc  out  32  DUT pc of first failing commit
mismatch_inst  out  32  DUT inst of first failing commit

Behaviour:
- Clock and reset: clk and reset; reset is synchronous and active-high.
- Reset values:
  - pc_hist[*] = 0, inst_hist[*] = 0.
  - count, cmp_valid and timer = 0; state = RUN.
  - All outputs 0.
- Change detect: each cycle in RUN, if pc != pc_hist[0], shift both histories.
  - hist[i] <= hist[i-1]; hist[0] <= {pc, inst}.
  - The entry shifted out of hist[HIST_DEPTH-1] is the candidate.
- Commit: candidate pc != 0. Candidates with pc == 0 are dropped silently and do not advance count.
- Compare pipeline:
  - gold_addr = count[ADDR_W-1:0] combinationally.
  - On a commit cycle t, capture the candidate into cmp_reg, set cmp_valid, and increment count.
  - At t+1, compare cmp_reg against gold_pc/gold_inst.
  - Sustains one commit per cycle, including back-to-back commits (ROM already holds addr count at t).
- Match: checked_count increments at t+1.
  - If checked_count reaches TRACE_LEN → PASS next cycle.
  - Commits arriving in the same cycle as the final match are ignored.
- Mismatch: at t+1 → FAIL.
  - Latch fail_code bit0/bit1 (both may be set), mismatch_idx = count at commit, mismatch_pc, mismatch_inst.
- Timeout: timer increments each RUN cycle with no pc change and clears on any change.
  - timer == TIMEOUT-1 with no change → FAIL, fail_code = 3'b100, mismatch_idx = checked_count, mismatch_pc = pc.
  - If a compare mismatch and the timeout fire in the same cycle, the mismatch bits win; bit2 is also set.
- States: RUN → PASS | FAIL. PASS and FAIL are terminal; histories freeze and outputs hold until reset.
- done = (state != RUN); pass = (state == PASS).
- Reset mid-run: synchronous reset on any edge returns to the reset values; an in-flight cmp_reg is discarded.
- Width: count is ADDR_W+1 bits and never exceeds TRACE_LEN in RUN; gold_addr never indexes past TRACE_LEN-1.

Test Plan:
- Golden ROM = 1000 entries generated from a model of the same 5-deep rule; CPU stub steps pc 0x00400000 + 4k, one change per cycle → PASS after the 1000th compare, checked_count = 1000, fail_code = 0.
- Same stream with entry 37's inst corrupted in the ROM → FAIL one cycle after commit 37, fail_code = 3'b010, mismatch_idx = 37, mismatch_pc = 0x00400094.
- pc held constant 4096 cycles after 10 commits → FAIL, fail_code = 3'b100, checked_count = 10.
- Stub repeats the same pc for 3 cycles between changes → each repeat ignored, no duplicate commits, PASS with count = 1000.
- First 5 changes after reset: zero-pc history entries shift out and are dropped → first commit compares against ROM[0], gold_addr = 0 until then.
- Reset asserted mid-run at commit 500 → next cycle all outputs 0, count = 0; rerun passes from the start.

Source files
------------

// File: rtl/commit_trace_checker.sv
`default_nettype none
// ============================================================================
//  Module   : commit_trace_checker
//  Purpose  : Rebuilds the commit sequence from the live CPU fetch stream and
//             compares it, in order, against a golden trace ROM. It reports
//             PASS after TRACE_LEN matching commits, or FAIL on the first
//             mismatch or when the pc stalls for too long.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             pc, inst            - current fetch pc / instruction
//             gold_addr           - golden ROM index (combinational from count)
//             gold_pc, gold_inst  - golden ROM data, 1-cycle synchronous read
//             checked_count       - number of commits compared and matched
//             done, pass          - terminal state indicators
//             fail_code           - {timeout, inst mismatch, pc mismatch}
//             mismatch_idx/pc/inst- details of the first failing commit
//  Revision : 1.0 - initial release
// ============================================================================
module commit_trace_checker #(
  parameter int TRACE_LEN  = 1000,
  parameter int ADDR_W     = 10,
  parameter int HIST_DEPTH = 5,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic [31:0]       inst,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [31:0]       gold_pc,
  input  logic [31:0]       gold_inst,
  output logic [ADDR_W:0]   checked_count,
  output logic              done,
  output logic              pass,
  output logic [2:0]        fail_code,
  output logic [ADDR_W:0]   mismatch_idx,
  output logic [31:0]       mismatch_pc,
  output logic [31:0]       mismatch_inst
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam int                 TIMER_W   = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]    LEN_C     = (ADDR_W + 1)'(TRACE_LEN);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(TRACE_LEN - 1);
  localparam logic [TIMER_W-1:0] TMO_LAST  = TIMER_W'(TIMEOUT - 1);

  // State
  logic [1:0]         state_q, state_d;
  logic [31:0]        pc_hist_q   [HIST_DEPTH];
  logic [31:0]        pc_hist_d   [HIST_DEPTH];
  logic [31:0]        inst_hist_q [HIST_DEPTH];
  logic [31:0]        inst_hist_d [HIST_DEPTH];
  logic [ADDR_W:0]    count_q, count_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               cmp_valid_q, cmp_valid_d;
  logic [31:0]        cmp_pc_q, cmp_pc_d;
  logic [31:0]        cmp_inst_q, cmp_inst_d;
  logic [ADDR_W:0]    cmp_idx_q, cmp_idx_d;
  logic [ADDR_W:0]    checked_count_q, checked_count_d;
  logic [2:0]         fail_code_q, fail_code_d;
  logic [ADDR_W:0]    mismatch_idx_q, mismatch_idx_d;
  logic [31:0]        mismatch_pc_q, mismatch_pc_d;
  logic [31:0]        mismatch_inst_q, mismatch_inst_d;

  // Per-cycle decode
  logic run;
  logic change;
  logic cmp_active;
  logic pc_bad;
  logic inst_bad;
  logic mism;
  logic match;
  logic final_match;
  logic tmo;
  logic commit;

  always_comb begin
    run         = (state_q == ST_RUN);
    change      = run && (pc != pc_hist_q[0]);
    cmp_active  = run && cmp_valid_q;
    pc_bad      = cmp_active && (cmp_pc_q   != gold_pc);
    inst_bad    = cmp_active && (cmp_inst_q != gold_inst);
    mism        = pc_bad || inst_bad;
    match       = cmp_active && !mism;
    final_match = match && ((checked_count_q + 1'b1) == LEN_C);
    tmo         = run && !change && (timer_q == TMO_LAST);
    // The evicted history entry is the commit candidate. Zero-pc entries are
    // the reset fill and never count; nothing new is issued once the trace
    // is fully issued or the run is ending this cycle.
    commit      = change && (pc_hist_q[HIST_DEPTH-1] != 32'd0) &&
                  (count_q != LEN_C) && !final_match && !mism;
  end

  always_comb begin
    state_d         = state_q;
    pc_hist_d       = pc_hist_q;
    inst_hist_d     = inst_hist_q;
    count_d         = count_q;
    timer_d         = timer_q;
    cmp_valid_d     = 1'b0;
    cmp_pc_d        = cmp_pc_q;
    cmp_inst_d      = cmp_inst_q;
    cmp_idx_d       = cmp_idx_q;
    checked_count_d = checked_count_q;
    fail_code_d     = fail_code_q;
    mismatch_idx_d  = mismatch_idx_q;
    mismatch_pc_d   = mismatch_pc_q;
    mismatch_inst_d = mismatch_inst_q;

    if (run) begin
      if (change) begin
        for (int i = HIST_DEPTH - 1; i > 0; i--) begin
          pc_hist_d[i]   = pc_hist_q[i-1];
          inst_hist_d[i] = inst_hist_q[i-1];
        end
        pc_hist_d[0]   = pc;
        inst_hist_d[0] = inst;
        timer_d        = '0;
      end else if (!tmo) begin
        timer_d = timer_q + 1'b1;
      end

      if (commit) begin
        cmp_valid_d = 1'b1;
        cmp_pc_d    = pc_hist_q[HIST_DEPTH-1];
        cmp_inst_d  = inst_hist_q[HIST_DEPTH-1];
        cmp_idx_d   = count_q;
        count_d     = count_q + 1'b1;
      end

      if (match) begin
        checked_count_d = checked_count_q + 1'b1;
        if (final_match) begin
          state_d = ST_PASS;
        end
      end

      if (mism || tmo) begin
        state_d     = ST_FAIL;
        fail_code_d = {tmo, inst_bad, pc_bad};
        // A compare mismatch owns the captured details even when the
        // timeout fires in the same cycle.
        if (mism) begin
          mismatch_idx_d  = cmp_idx_q;
          mismatch_pc_d   = cmp_pc_q;
          mismatch_inst_d = cmp_inst_q;
        end else begin
          mismatch_idx_d  = checked_count_q;
          mismatch_pc_d   = pc;
          mismatch_inst_d = inst;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_RUN;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        pc_hist_q[i]   <= '0;
        inst_hist_q[i] <= '0;
      end
      count_q         <= '0;
      timer_q         <= '0;
      cmp_valid_q     <= 1'b0;
      cmp_pc_q        <= '0;
      cmp_inst_q      <= '0;
      cmp_idx_q       <= '0;
      checked_count_q <= '0;
      fail_code_q     <= '0;
      mismatch_idx_q  <= '0;
      mismatch_pc_q   <= '0;
      mismatch_inst_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_hist_q       <= pc_hist_d;
      inst_hist_q     <= inst_hist_d;
      count_q         <= count_d;
      timer_q         <= timer_d;
      cmp_valid_q     <= cmp_valid_d;
      cmp_pc_q        <= cmp_pc_d;
      cmp_inst_q      <= cmp_inst_d;
      cmp_idx_q       <= cmp_idx_d;
      checked_count_q <= checked_count_d;
      fail_code_q     <= fail_code_d;
      mismatch_idx_q  <= mismatch_idx_d;
      mismatch_pc_q   <= mismatch_pc_d;
      mismatch_inst_q <= mismatch_inst_d;
    end
  end

  // The ROM is addressed by the next commit index; once the whole trace has
  // been issued the address parks on the last valid entry.
  assign gold_addr     = (count_q >= LEN_C) ? LAST_ADDR : count_q[ADDR_W-1:0];
  assign checked_count = checked_count_q;
  assign done          = (state_q != ST_RUN);
  assign pass          = (state_q == ST_PASS);
  assign fail_code     = fail_code_q;
  assign mismatch_idx  = mismatch_idx_q;
  assign mismatch_pc   = mismatch_pc_q;
  assign mismatch_inst = mismatch_inst_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commit_trace_checker
//  Purpose  : Scoreboard bench for commit_trace_checker. A CPU stub drives a
//             stepping pc stream; a golden ROM model answers gold_addr. The
//             stimulus pushes expected checked_count steps and the expected
//             terminal result; a monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_commit_trace_checker;

  localparam int TRACE_LEN = 1000;
  localparam int ADDR_W    = 10;

  typedef struct {
    logic        pass;
    logic [2:0]  code;
    logic [10:0] cc;
    logic [10:0] idx;
    logic [31:0] mpc;
    logic [31:0] minst;
  } end_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       pc;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] gold_addr;
  logic [31:0]       gold_pc;
  logic [31:0]       gold_inst;
  logic [ADDR_W:0]   checked_count;
  logic              done;
  logic              pass;
  logic [2:0]        fail_code;
  logic [ADDR_W:0]   mismatch_idx;
  logic [31:0]       mismatch_pc;
  logic [31:0]       mismatch_inst;

  commit_trace_checker #(
    .TRACE_LEN(TRACE_LEN), .ADDR_W(ADDR_W), .HIST_DEPTH(5), .TIMEOUT(4096)
  ) dut (
    .clk(clk), .reset(reset), .pc(pc), .inst(inst),
    .gold_addr(gold_addr), .gold_pc(gold_pc), .gold_inst(gold_inst),
    .checked_count(checked_count), .done(done), .pass(pass),
    .fail_code(fail_code), .mismatch_idx(mismatch_idx),
    .mismatch_pc(mismatch_pc), .mismatch_inst(mismatch_inst)
  );

  always #5 clk = ~clk;

  logic [31:0] rom_pc   [1024];
  logic [31:0] rom_inst [1024];

  always @(posedge clk) begin
    gold_pc   <= rom_pc[gold_addr];
    gold_inst <= rom_inst[gold_addr];
  end

  int   checks = 0;
  int   errors = 0;
  int   exp_cnt_q[$];
  end_t exp_end_q[$];

  function automatic logic [31:0] pc_of(int k);
    return 32'h0040_0000 + 32'(k) * 32'd4;
  endfunction

  function automatic logic [31:0] inst_of(int k);
    return 32'h0000_0013 + 32'(k) * 32'h80;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected count per checked_count step and the
  // expected terminal result when done rises.
  logic [ADDR_W:0] prev_cc = '0;
  logic            prev_done = 1'b0;
  always @(negedge clk) begin
    if (checked_count == prev_cc + 1'b1) begin
      if (exp_cnt_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_count_step: got %0d, expected no step", checked_count);
      end else begin
        check("checked_count_step", 32'(checked_count), 32'(exp_cnt_q.pop_front()));
      end
    end
    prev_cc = checked_count;
    if (done && !prev_done) begin
      if (exp_end_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no terminal state");
      end else begin
        end_t e;
        e = exp_end_q.pop_front();
        check("end_pass",          32'(pass),          32'(e.pass));
        check("end_fail_code",     32'(fail_code),     32'(e.code));
        check("end_checked_count", 32'(checked_count), 32'(e.cc));
        check("end_mismatch_idx",  32'(mismatch_idx),  32'(e.idx));
        check("end_mismatch_pc",   mismatch_pc,        e.mpc);
        check("end_mismatch_inst", mismatch_inst,      e.minst);
      end
    end
    prev_done = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int from, int to, int rep);
    for (int k = from; k < to; k++) begin
      if (done) break;
      pc   = pc_of(k);
      inst = inst_of(k);
      repeat (rep) tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pc    = '0;
    inst  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_counts(int n);
    for (int i = 1; i <= n; i++) exp_cnt_q.push_back(i);
  endtask

  task automatic push_end(logic p, logic [2:0] c, int cc, int idx,
                          logic [31:0] mpc, logic [31:0] minst);
    end_t e;
    e.pass = p; e.code = c; e.cc = 11'(cc); e.idx = 11'(idx);
    e.mpc = mpc; e.minst = minst;
    exp_end_q.push_back(e);
  endtask

  task automatic wait_done(string name, int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (done) break;
      tick();
    end
    tick();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got done=0, expected done=1", name);
    end
    check({name, "_cnt_drained"}, 32'(exp_cnt_q.size()), 32'd0);
    check({name, "_end_drained"}, 32'(exp_end_q.size()), 32'd0);
  endtask

  task automatic check_zero(string name);
    check({name, "_checked_count"}, 32'(checked_count), 32'd0);
    check({name, "_done"},          32'(done),          32'd0);
    check({name, "_pass"},          32'(pass),          32'd0);
    check({name, "_fail_code"},     32'(fail_code),     32'd0);
    check({name, "_mismatch_idx"},  32'(mismatch_idx),  32'd0);
    check({name, "_mismatch_pc"},   mismatch_pc,        32'd0);
    check({name, "_mismatch_inst"}, mismatch_inst,      32'd0);
    check({name, "_gold_addr"},     32'(gold_addr),     32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rom_pc[i]   = (i < TRACE_LEN) ? pc_of(i)   : 32'd0;
      rom_inst[i] = (i < TRACE_LEN) ? inst_of(i) : 32'd0;
    end
    reset = 1'b1;
    pc    = '0;
    inst  = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_zero("reset");

    // Full clean stream, one change per cycle; the first five changes only
    // flush zero-pc entries and leave the ROM index at 0.
    push_counts(TRACE_LEN);
    push_end(1'b1, 3'b000, TRACE_LEN, 0, 32'd0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      pc   = pc_of(k);
      inst = inst_of(k);
      tick();
      check("warmup_gold_addr", 32'(gold_addr), 32'd0);
    end
    check("warmup_checked_count", 32'(checked_count), 32'd0);
    drive(5, TRACE_LEN + 5, 1);
    wait_done("clean", 50);
    do_reset();

    // Corrupted instruction at ROM entry 37.
    rom_inst[37] = inst_of(37) ^ 32'h0000_1000;
    push_counts(37);
    push_end(1'b0, 3'b010, 37, 37, 32'h0040_0094, inst_of(37));
    drive(0, TRACE_LEN + 5, 1);
    wait_done("corrupt", 50);
    rom_inst[37] = inst_of(37);
    do_reset();

    // Ten commits, then the pc stalls until the timeout fires.
    push_counts(10);
    push_end(1'b0, 3'b100, 10, 10, pc_of(14), inst_of(14));
    drive(0, 15, 1);
    wait_done("stall", 5000);
    do_reset();

    // Every pc held for three cycles: repeats must not duplicate commits.
    push_counts(TRACE_LEN);
    push_end(1'b1, 3'b000, TRACE_LEN, 0, 32'd0, 32'd0);
    drive(0, TRACE_LEN + 5, 3);
    wait_done("repeat", 50);
    do_reset();

    // Reset in the middle of the run, then a full rerun.
    push_counts(TRACE_LEN);
    for (int k = 0; k < TRACE_LEN + 5; k++) begin
      if (checked_count >= 11'd500) break;
      pc   = pc_of(k);
      inst = inst_of(k);
      tick();
    end
    check("midrun_reached_500", 32'(checked_count), 32'd500);
    reset = 1'b1;
    pc    = '0;
    inst  = '0;
    tick();
    check_zero("midrun_reset");
    exp_cnt_q.delete();
    tick();
    reset = 1'b0;
    push_counts(TRACE_LEN);
    push_end(1'b1, 3'b000, TRACE_LEN, 0, 32'd0, 32'd0);
    drive(0, TRACE_LEN + 5, 1);
    wait_done("rerun", 50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
